// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and encodings for the ID-stage hazard controller.
package hazard_ctrl_pkg;

    localparam int unsigned RF_ADDR_WD = 5;
    localparam int unsigned RF_NUM     = 32;
    localparam int unsigned SB_CNT_WD  = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_src_sel.sv
// Bypass select and not-ready detection for a single ID source operand.
module hazard_src_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [RF_ADDR_WD-1:0] src,
    input  logic                  src_use,
    input  logic [RF_ADDR_WD-1:0] exe_rd,
    input  logic                  exe_valid,
    input  logic                  exe_we,
    input  logic                  exe_dv,
    input  logic [RF_ADDR_WD-1:0] mem_rd,
    input  logic                  mem_valid,
    input  logic                  mem_we,
    input  logic                  mem_dv,
    input  logic [RF_ADDR_WD-1:0] wb_rd,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic                  sb_pending,
    output logic [1:0]            fwd,
    output logic                  not_ready
);

    logic exe_hit, mem_hit, wb_hit;

    assign exe_hit = exe_valid & exe_we & (exe_rd == src);
    assign mem_hit = mem_valid & mem_we & (mem_rd == src);
    assign wb_hit  = wb_valid  & wb_we  & (wb_rd  == src);

    // Youngest producer wins; the scoreboard only catches writers no stage reports.
    always_comb begin
        fwd       = FWD_RF;
        not_ready = 1'b0;
        if (src_use && src != '0) begin
            if (exe_hit) begin
                if (exe_dv) fwd = FWD_EXE;
                else        not_ready = 1'b1;
            end else if (mem_hit) begin
                if (mem_dv) fwd = FWD_MEM;
                else        not_ready = 1'b1;
            end else if (wb_hit) begin
                fwd = FWD_WB;
            end else if (sb_pending) begin
                not_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock: in-flight write scoreboard, operand bypass select, stall FSM.
// Optional perf counters enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_valid,
    input  logic [RF_ADDR_WD-1:0] id_rj,
    input  logic [RF_ADDR_WD-1:0] id_rk,
    input  logic                  id_rj_use,
    input  logic                  id_rk_use,
    input  logic [RF_ADDR_WD-1:0] id_rd,
    input  logic                  id_rf_we,
    input  logic                  id_to_exe_go,
    input  logic [RF_ADDR_WD-1:0] exe_rd,
    input  logic [RF_ADDR_WD-1:0] mem_rd,
    input  logic [RF_ADDR_WD-1:0] wb_rd,
    input  logic                  exe_valid,
    input  logic                  mem_valid,
    input  logic                  wb_valid,
    input  logic                  exe_we,
    input  logic                  mem_we,
    input  logic                  wb_we,
    input  logic                  exe_dv,
    input  logic                  mem_dv,
    input  logic                  flush_all,
    output logic [1:0]            rj_fwd,
    output logic [1:0]            rk_fwd,
    output logic                  id_stall,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           stall_events,
    output logic                  sb_busy
`else
    output logic                  sb_busy
`endif
);

    logic [SB_CNT_WD-1:0] sb [RF_NUM];
    logic [RF_NUM-1:0]    inc_vec, dec_vec;
    logic                 issue, retire;
    logic [1:0]           rj_sel, rk_sel;
    logic                 rj_nr, rk_nr;
    hz_state_e            state;

    assign issue  = id_valid & id_to_exe_go & id_rf_we & (id_rd != '0) & ~flush_all;
    assign retire = wb_valid & wb_we & (wb_rd != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue)  inc_vec[id_rd] = 1'b1;
        if (retire) dec_vec[wb_rd] = 1'b1;
    end

    // Entry 0 is never incremented because both events exclude r0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < RF_NUM; i++) sb[i] <= '0;
        end else if (flush_all) begin
            for (int unsigned i = 0; i < RF_NUM; i++) sb[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < RF_NUM; i++) begin
                unique case ({inc_vec[i], dec_vec[i]})
                    2'b10:   if (sb[i] != '1) sb[i] <= sb[i] + 1'b1;
                    2'b01:   if (sb[i] != '0) sb[i] <= sb[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int unsigned i = 0; i < RF_NUM; i++) sb_busy = sb_busy | (sb[i] != '0);
    end

    hazard_src_sel u_rj_sel (
        .src(id_rj), .src_use(id_rj_use),
        .exe_rd(exe_rd), .exe_valid(exe_valid), .exe_we(exe_we), .exe_dv(exe_dv),
        .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_we(mem_we), .mem_dv(mem_dv),
        .wb_rd(wb_rd), .wb_valid(wb_valid), .wb_we(wb_we),
        .sb_pending(sb[id_rj] != '0),
        .fwd(rj_sel), .not_ready(rj_nr)
    );

    hazard_src_sel u_rk_sel (
        .src(id_rk), .src_use(id_rk_use),
        .exe_rd(exe_rd), .exe_valid(exe_valid), .exe_we(exe_we), .exe_dv(exe_dv),
        .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_we(mem_we), .mem_dv(mem_dv),
        .wb_rd(wb_rd), .wb_valid(wb_valid), .wb_we(wb_we),
        .sb_pending(sb[id_rk] != '0),
        .fwd(rk_sel), .not_ready(rk_nr)
    );

    assign rj_fwd   = resetn ? rj_sel : FWD_RF;
    assign rk_fwd   = resetn ? rk_sel : FWD_RF;
    assign id_stall = resetn & id_valid & (rj_nr | rk_nr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= HZ_RUN;
`ifdef HAZARD_PERF_CNT_EN
            stall_cycles <= '0;
            stall_events <= '0;
`endif
        end else begin
            unique case (state)
                HZ_RUN:   if (id_stall) state <= HZ_STALL;
                HZ_STALL: if (!id_stall || flush_all) state <= HZ_RUN;
                default:  state <= HZ_RUN;
            endcase
`ifdef HAZARD_PERF_CNT_EN
            if (id_stall) stall_cycles <= stall_cycles + 32'd1;
            if (id_stall && state == HZ_RUN) stall_events <= stall_events + 32'd1;
`endif
        end
    end

    SB_OVF: assert property (@(posedge clk) disable iff (!resetn)
        !(issue && !(retire && wb_rd == id_rd) && sb[id_rd] == '1));

    SB_UNF: assert property (@(posedge clk) disable iff (!resetn)
        !(retire && !flush_all && !(issue && wb_rd == id_rd) && sb[wb_rd] == '0));

    HZ_TRACK: assert property (@(posedge clk) disable iff (!resetn)
        (id_stall && !(state == HZ_STALL && flush_all)) |=> state == HZ_STALL);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized pipeline traffic.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       id_valid, id_rj_use, id_rk_use, id_rf_we, id_to_exe_go;
    logic [4:0] id_rj, id_rk, id_rd, exe_rd, mem_rd, wb_rd;
    logic       exe_valid, mem_valid, wb_valid, exe_we, mem_we, wb_we;
    logic       exe_dv, mem_dv, flush_all;
    logic [1:0] rj_fwd, rk_fwd;
    logic       id_stall, sb_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, stall_events;
    int unsigned exp_cyc, exp_evt;
    bit          st_stall;
`endif

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       edv;
        logic       mdv;
    } ins_t;

    ins_t pipe [3];   // 0 = EXE, 1 = MEM, 2 = WB

    hazard_ctrl dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_rj(id_rj), .id_rk(id_rk),
        .id_rj_use(id_rj_use), .id_rk_use(id_rk_use),
        .id_rd(id_rd), .id_rf_we(id_rf_we), .id_to_exe_go(id_to_exe_go),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .exe_we(exe_we), .mem_we(mem_we), .wb_we(wb_we),
        .exe_dv(exe_dv), .mem_dv(mem_dv), .flush_all(flush_all),
        .rj_fwd(rj_fwd), .rk_fwd(rk_fwd), .id_stall(id_stall),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .stall_events(stall_events),
`endif
        .sb_busy(sb_busy)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_valid = 0; id_rj = 0; id_rk = 0; id_rj_use = 0; id_rk_use = 0;
        id_rd = 0; id_rf_we = 0; id_to_exe_go = 0;
        exe_rd = 0; mem_rd = 0; wb_rd = 0;
        exe_valid = 0; mem_valid = 0; wb_valid = 0;
        exe_we = 0; mem_we = 0; wb_we = 0; exe_dv = 0; mem_dv = 0; flush_all = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        resetn = 0;
        tick();
        resetn = 1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        exe_valid = 1; exe_we = 1; exe_rd = 5'd4; exe_dv = 1; id_rj = 5'd4; id_rj_use = 1;
        #2;
        vectors++;
        if (rj_fwd !== 2'd0 || rk_fwd !== 2'd0) begin
            errors++; $display("FAIL reset_fwd rj=%0d rk=%0d exp=0", rj_fwd, rk_fwd);
        end
        vectors++;
        if (id_stall !== 1'b0 || sb_busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags stall=%0b busy=%0b exp=0", id_stall, sb_busy);
        end
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_cycles !== 0 || stall_events !== 0) begin
            errors++; $display("FAIL reset_perf cyc=%0d evt=%0d exp=0", stall_cycles, stall_events);
        end
`endif
        apply_reset();
    endtask

    task automatic test_fwd_exe();
        idle();
        exe_valid = 1; exe_we = 1; exe_rd = 5'd4; exe_dv = 1;
        id_valid = 1; id_rj = 5'd4; id_rj_use = 1;
        #1;
        vectors++;
        if (rj_fwd !== 2'd1 || id_stall !== 1'b0) begin
            errors++; $display("FAIL fwd_exe rj_fwd=%0d stall=%0b exp=1/0", rj_fwd, id_stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        exe_valid = 1; exe_we = 1; exe_rd = 5'd5; exe_dv = 0;
        id_valid = 1; id_rk = 5'd5; id_rk_use = 1;
        #1;
        vectors++;
        if (id_stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall stall=%0b exp=1", id_stall);
        end
        tick();
        exe_valid = 0; exe_we = 0;
        mem_valid = 1; mem_we = 1; mem_rd = 5'd5; mem_dv = 1;
        #1;
        vectors++;
        if (rk_fwd !== 2'd2 || id_stall !== 1'b0) begin
            errors++; $display("FAIL load_use_mem rk_fwd=%0d stall=%0b exp=2/0", rk_fwd, id_stall);
        end
        tick();
    endtask

    task automatic test_youngest();
        idle();
        exe_valid = 1; exe_we = 1; exe_rd = 5'd6; exe_dv = 1;
        wb_valid = 1; wb_we = 1; wb_rd = 5'd6;
        id_valid = 1; id_rj = 5'd6; id_rj_use = 1;
        #1;
        vectors++;
        if (rj_fwd !== 2'd1) begin
            errors++; $display("FAIL youngest_exe rj_fwd=%0d exp=1", rj_fwd);
        end
        exe_valid = 0;
        #1;
        vectors++;
        if (rj_fwd !== 2'd3) begin
            errors++; $display("FAIL wb_only rj_fwd=%0d exp=3", rj_fwd);
        end
        // WB-only is observed combinationally; remove it before the edge to avoid a retire.
        idle();
        tick();
    endtask

    task automatic test_issue_retire_same();
        idle();
        id_valid = 1; id_to_exe_go = 1; id_rf_we = 1; id_rd = 5'd7;
        tick();
        vectors++;
        if (sb_busy !== 1'b1) begin
            errors++; $display("FAIL sb_after_issue busy=%0b exp=1", sb_busy);
        end
        wb_valid = 1; wb_we = 1; wb_rd = 5'd7;
        tick();
        idle();
        id_valid = 1; id_rj = 5'd7; id_rj_use = 1;
        #1;
        vectors++;
        if (sb_busy !== 1'b1 || id_stall !== 1'b1) begin
            errors++; $display("FAIL issue_retire_same busy=%0b stall=%0b exp=1/1", sb_busy, id_stall);
        end
        idle();
        wb_valid = 1; wb_we = 1; wb_rd = 5'd7;
        tick();
        idle();
        #1;
        vectors++;
        if (sb_busy !== 1'b0) begin
            errors++; $display("FAIL sb_drain busy=%0b exp=0", sb_busy);
        end
    endtask

    task automatic test_flush();
        idle();
        id_valid = 1; id_to_exe_go = 1; id_rf_we = 1; id_rd = 5'd8;
        repeat (3) tick();
        idle();
        vectors++;
        if (sb_busy !== 1'b1) begin
            errors++; $display("FAIL pre_flush busy=%0b exp=1", sb_busy);
        end
        flush_all = 1;
        tick();
        flush_all = 0;
        id_valid = 1; id_rj = 5'd8; id_rj_use = 1;
        #1;
        vectors++;
        if (sb_busy !== 1'b0 || rj_fwd !== 2'd0 || id_stall !== 1'b0) begin
            errors++; $display("FAIL flush busy=%0b fwd=%0d stall=%0b exp=0/0/0", sb_busy, rj_fwd, id_stall);
        end
        tick();
    endtask

    task automatic test_r0();
        idle();
        exe_valid = 1; exe_we = 1; exe_rd = 5'd0; exe_dv = 0;
        id_valid = 1; id_rj = 5'd0; id_rj_use = 1;
        #1;
        vectors++;
        if (rj_fwd !== 2'd0 || id_stall !== 1'b0) begin
            errors++; $display("FAIL r0 rj_fwd=%0d stall=%0b exp=0/0", rj_fwd, id_stall);
        end
        tick();
    endtask

    task automatic test_stall3();
        apply_reset();
        exe_valid = 1; exe_we = 1; exe_rd = 5'd5; exe_dv = 0;
        id_valid = 1; id_rj = 5'd5; id_rj_use = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (id_stall !== 1'b1) begin
                errors++; $display("FAIL stall3 cycle=%0d stall=%0b exp=1", i, id_stall);
            end
            tick();
        end
        idle();
        tick();
`ifdef HAZARD_PERF_CNT_EN
        vectors++;
        if (stall_cycles !== 32'd3 || stall_events !== 32'd1) begin
            errors++; $display("FAIL perf cyc=%0d evt=%0d exp=3/1", stall_cycles, stall_events);
        end
`endif
    endtask

    function automatic logic [1:0] ref_sel(input logic [4:0] src, input logic use_it, output logic nr);
        int unsigned pend;
        nr = 1'b0;
        if (!use_it || src == 5'd0) return 2'd0;
        for (int s = 0; s < 3; s++) begin
            if (pipe[s].v && pipe[s].we && pipe[s].rd == src) begin
                if ((s == 0 && !pipe[s].edv) || (s == 1 && !pipe[s].mdv)) begin
                    nr = 1'b1;
                    return 2'd0;
                end
                return 2'(s + 1);
            end
        end
        pend = 0;
        for (int s = 0; s < 3; s++) pend += (pipe[s].v && pipe[s].we && pipe[s].rd == src) ? 1 : 0;
        if (pend != 0) nr = 1'b1;
        return 2'd0;
    endfunction

    task automatic test_random();
        logic [1:0] ej, ek;
        logic       nj, nk, est, ebusy, go;
        ins_t       nw;
        int unsigned kind;
        apply_reset();
        for (int s = 0; s < 3; s++) pipe[s] = '0;
`ifdef HAZARD_PERF_CNT_EN
        exp_cyc = 0; exp_evt = 0; st_stall = 0;
`endif
        for (int n = 0; n < 1500; n++) begin
            idle();
            id_valid  = ($urandom % 4) != 0;
            id_rj     = 5'($urandom % 8);
            id_rk     = 5'($urandom % 8);
            id_rj_use = $urandom % 2;
            id_rk_use = $urandom % 2;
            id_rd     = 5'($urandom % 8);
            id_rf_we  = $urandom % 2;
            flush_all = ($urandom % 40) == 0;
            kind = $urandom % 4;
            nw.v = 1; nw.we = id_rf_we; nw.rd = id_rd;
            nw.edv = (kind >= 2); nw.mdv = (kind != 1);
            exe_valid = pipe[0].v; exe_we = pipe[0].we; exe_rd = pipe[0].rd;
            exe_dv = pipe[0].edv;
            mem_valid = pipe[1].v; mem_we = pipe[1].we; mem_rd = pipe[1].rd;
            mem_dv = pipe[1].mdv;
            wb_valid = pipe[2].v; wb_we = pipe[2].we; wb_rd = pipe[2].rd;
            ej = ref_sel(id_rj, id_rj_use, nj);
            ek = ref_sel(id_rk, id_rk_use, nk);
            est = id_valid && (nj || nk);
            go = id_valid && !est;
            id_to_exe_go = go;
            ebusy = 0;
            for (int s = 0; s < 3; s++) ebusy |= pipe[s].v && pipe[s].we && pipe[s].rd != 0;
            #1;
            vectors++;
            if (id_stall !== est) begin
                errors++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, id_stall, est);
            end
            vectors++;
            if ((!nj && rj_fwd !== ej) || (!nk && rk_fwd !== ek)) begin
                errors++; $display("FAIL rnd_fwd n=%0d rj=%0d/%0d rk=%0d/%0d", n, rj_fwd, ej, rk_fwd, ek);
            end
            vectors++;
            if (sb_busy !== ebusy) begin
                errors++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, sb_busy, ebusy);
            end
`ifdef HAZARD_PERF_CNT_EN
            vectors++;
            if (stall_cycles !== exp_cyc || stall_events !== exp_evt) begin
                errors++; $display("FAIL rnd_perf n=%0d cyc=%0d/%0d evt=%0d/%0d", n, stall_cycles, exp_cyc, stall_events, exp_evt);
            end
            if (est) exp_cyc++;
            if (est && !st_stall) exp_evt++;
            st_stall = est && !(st_stall && flush_all);
`endif
            @(posedge clk);
            if (flush_all) begin
                for (int s = 0; s < 3; s++) pipe[s] = '0;
            end else begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = go ? nw : '0;
            end
            #1;
        end
        idle();
    endtask

    task automatic test_async_reset();
        apply_reset();
        id_valid = 1; id_to_exe_go = 1; id_rf_we = 1; id_rd = 5'd3;
        tick();
        idle();
        vectors++;
        if (sb_busy !== 1'b1) begin
            errors++; $display("FAIL async_pre busy=%0b exp=1", sb_busy);
        end
        #2;
        resetn = 0;
        #1;
        vectors++;
        if (sb_busy !== 1'b0) begin
            errors++; $display("FAIL async_reset busy=%0b exp=0", sb_busy);
        end
        tick();
        resetn = 1;
        id_valid = 1; id_rj = 5'd3; id_rj_use = 1;
        #1;
        vectors++;
        if (id_stall !== 1'b0 || rj_fwd !== 2'd0) begin
            errors++; $display("FAIL async_post stall=%0b fwd=%0d exp=0/0", id_stall, rj_fwd);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fwd_exe();
        test_load_use();
        test_youngest();
        test_issue_retire_same();
        test_flush();
        test_r0();
        test_stall3();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
